// File: rtl/matrix_key_pkg.sv
// Shared keypad constants and scan FSM state type; also used by the key-emulation side.
package matrix_key_pkg;

  localparam logic ROW_ACTIVE   = 1'b0;
  localparam logic ROW_INACTIVE = 1'b1;
  localparam logic COL_PRESSED  = 1'b0;
  localparam logic COL_RELEASED = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StUpdate
  } scan_state_e;

endpackage

// File: rtl/key_col_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines; resets to "released".
module key_col_sync
  import matrix_key_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] col_async,
  output logic [WIDTH-1:0] col_sync
);

  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= {WIDTH{COL_RELEASED}};
      sync_q <= {WIDTH{COL_RELEASED}};
    end else begin
      meta_q <= col_async;
      sync_q <= meta_q;
    end
  end

  assign col_sync = sync_q;

endmodule

// File: rtl/matrix_key_scan.sv
// Matrix keypad scanner: drives one row low at a time, samples synchronized columns and
// debounces whole-matrix frames. Define MATRIX_KEY_GHOST_FILTER_EN to reject ambiguous frames.
module matrix_key_scan
  import matrix_key_pkg::*;
#(
  parameter int unsigned ROW_NUM        = 4,
  parameter int unsigned COL_NUM        = 4,
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       scan_enable,
  output logic [ROW_NUM-1:0]         row,
  input  logic [COL_NUM-1:0]         col,
  output logic [ROW_NUM*COL_NUM-1:0] key_state,
  output logic                       key_change,
  output logic                       ghost_flag
);

  localparam int unsigned KeyNum = ROW_NUM * COL_NUM;
  localparam int unsigned IdxW   = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int unsigned SetW   = $clog2(SETTLE_CYCLES);
  localparam int unsigned CntW   = $clog2(DEBOUNCE_SCANS + 1);

  scan_state_e       state_q, state_d;
  logic [IdxW-1:0]   idx_q;
  logic [SetW-1:0]   settle_q;
  logic [KeyNum-1:0] raw_q, prev_q, key_state_q;
  logic [CntW-1:0]   stable_q, stable_upd;
  logic              key_change_q;
  logic              frame_ok, settle_last, idx_last;
  logic [COL_NUM-1:0] col_sync;

  key_col_sync #(
    .WIDTH(COL_NUM)
  ) u_col_sync (
    .clk      (clk),
    .rstn     (rstn),
    .col_async(col),
    .col_sync (col_sync)
  );

  assign settle_last = (settle_q == SetW'(SETTLE_CYCLES - 1));
  assign idx_last    = (idx_q == IdxW'(ROW_NUM - 1));

  always_comb begin
    stable_upd = CntW'(1);
    if (raw_q == prev_q) begin
      stable_upd = (stable_q == CntW'(DEBOUNCE_SCANS)) ? stable_q : stable_q + 1'b1;
    end
  end

`ifdef MATRIX_KEY_GHOST_FILTER_EN
  // Two rows sharing two pressed columns cannot be resolved without diodes.
  function automatic logic frame_ambiguous(input logic [KeyNum-1:0] frame);
    logic               amb;
    logic [COL_NUM-1:0] common;
    amb = 1'b0;
    for (int r1 = 0; r1 < ROW_NUM; r1++) begin
      for (int r2 = r1 + 1; r2 < ROW_NUM; r2++) begin
        common = frame[r1*COL_NUM +: COL_NUM] & frame[r2*COL_NUM +: COL_NUM];
        if ($countones(common) >= 2) amb = 1'b1;
      end
    end
    return amb;
  endfunction

  logic ghost_q;

  assign frame_ok = !frame_ambiguous(raw_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghost_q <= 1'b0;
    end else if (state_q == StUpdate) begin
      ghost_q <= !frame_ok;
    end
  end

  assign ghost_flag = ghost_q;
`else
  assign frame_ok   = 1'b1;
  assign ghost_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (scan_enable) state_d = StDrive;
      StDrive: begin
        if (!scan_enable)     state_d = StIdle;
        else if (settle_last) state_d = StSample;
      end
      StSample: begin
        if (!scan_enable)  state_d = StIdle;
        else if (idx_last) state_d = StUpdate;
        else               state_d = StDrive;
      end
      StUpdate: state_d = scan_enable ? StDrive : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    row = {ROW_NUM{ROW_INACTIVE}};
    if (state_q == StDrive || state_q == StSample) row[idx_q] = ROW_ACTIVE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q        <= '0;
      settle_q     <= '0;
      raw_q        <= '0;
      prev_q       <= '0;
      stable_q     <= '0;
      key_state_q  <= '0;
      key_change_q <= 1'b0;
    end else begin
      key_change_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          idx_q    <= '0;
          settle_q <= '0;
        end
        StDrive: begin
          if (!scan_enable) begin
            idx_q    <= '0;
            settle_q <= '0;
            stable_q <= '0;
          end else if (settle_last) begin
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StSample: begin
          if (!scan_enable) begin
            idx_q    <= '0;
            stable_q <= '0;
          end else begin
            raw_q[idx_q*COL_NUM +: COL_NUM] <= col_sync ~^ {COL_NUM{COL_PRESSED}};
            idx_q <= idx_last ? '0 : idx_q + 1'b1;
          end
        end
        StUpdate: begin
          idx_q <= '0;
          if (!frame_ok) begin
            stable_q <= '0;
          end else begin
            stable_q <= stable_upd;
            prev_q   <= raw_q;
            if (stable_upd >= CntW'(DEBOUNCE_SCANS) && raw_q != key_state_q) begin
              key_state_q  <= raw_q;
              key_change_q <= 1'b1;
            end
          end
        end
        default: idx_q <= '0;
      endcase
    end
  end

  assign key_state  = key_state_q;
  assign key_change = key_change_q;

endmodule
